// File: rtl/avalon_mm_sink_responder.sv
// avalon_mm_sink_responder: Avalon-MM slave with programmable stalls, word buffer and pipelined reads
module avalon_mm_sink_responder #(
  parameter int ADDRESSWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int DEPTH = 256,
  parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_CYCLES = 3,
  parameter int READ_LATENCY = 2,
  parameter logic [DATAWIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDRESSWIDTH-1:0]    address,
  input  logic [DATAWIDTH-1:0]       writedata,
  input  logic                       write,
  input  logic                       read,
  input  logic                       clear,
  output logic                       waitrequest,
  output logic [DATAWIDTH-1:0]       readdata,
  output logic                       readdatavalid,
  output logic [$clog2(DEPTH):0]     write_count,
  output logic                       full,
  output logic                       addr_error,
  output logic                       proto_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  typedef enum logic {IDLE, STALL} state_t;
  state_t state;
  logic [SW-1:0] scnt;
  logic [ADDRESSWIDTH-1:0] off;
  logic [AW-1:0] index;
  logic borrow, req, accept, in_range, wr_acc, rd_acc, unused_off;
  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [READ_LATENCY-1:0] v;
  logic [DATAWIDTH-1:0] d [READ_LATENCY];
  always_comb begin
    req = write | read;
    waitrequest = req && (state == IDLE ? WAIT_CYCLES != 0 : scnt != SW'(WAIT_CYCLES));
    accept = req && !waitrequest;
    {borrow, off} = {1'b0, address} - {1'b0, BASE_ADDR};
    index = off[AW+1:2];
    in_range = !borrow && off[ADDRESSWIDTH-1:AW+2] == '0;
    wr_acc = accept && write;
    rd_acc = accept && read && !write;
    full = write_count == CW'(DEPTH);
    readdatavalid = v[READ_LATENCY-1];
    readdata = d[READ_LATENCY-1];
    unused_off = ^off[1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      scnt <= '0;
      write_count <= '0;
      addr_error <= 1'b0;
      proto_error <= 1'b0;
    end else begin
      state <= req && !accept ? STALL : IDLE;
      scnt <= req && !accept ? scnt + 1'b1 : '0;
      if (clear) begin
        write_count <= '0;
        addr_error <= 1'b0;
        proto_error <= 1'b0;
      end else begin
        if (wr_acc && in_range && !full) write_count <= write_count + 1'b1;
        if (accept && !in_range) addr_error <= 1'b1;
        if (wr_acc && read) proto_error <= 1'b1;
      end
    end
  end
  // buffer contents survive reset
  always_ff @(posedge clk) if (wr_acc && in_range) mem[index] <= writedata;
  // data stages only load behind a valid so readdata holds its last value
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= rd_acc;
      if (rd_acc) d[0] <= in_range ? mem[index] : ERR_DATA;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end
endmodule

// File: tb/tb_avalon_mm_sink_responder.sv
// tb_avalon_mm_sink_responder: scoreboard bench for the Avalon-MM sink responder
module tb_avalon_mm_sink_responder;
  localparam int RL = 2;
  localparam int WC = 3;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 0, rst = 1, write = 0, read = 0, clear = 0;
  logic [31:0] address = 0, writedata = 0;
  logic waitrequest, readdatavalid, full, addr_error, proto_error;
  logic [31:0] readdata;
  logic [8:0] write_count;
  typedef struct {logic [31:0] d; int c;} exp_t;
  exp_t q[$];
  logic [31:0] model [256];
  int total = 0, bad = 0, cyc = 0, st;

  avalon_mm_sink_responder dut (
    .clk(clk), .rst(rst), .address(address), .writedata(writedata), .write(write),
    .read(read), .clear(clear), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .write_count(write_count), .full(full),
    .addr_error(addr_error), .proto_error(proto_error));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && readdatavalid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL rdv_unexpected: readdatavalid=1 data=%h at cycle %0d, none expected", readdata, cyc);
      end else begin
        e = q.pop_front();
        if (readdata !== e.d || cyc !== e.c) begin
          bad++;
          $display("FAIL rdv_data: got %h at cycle %0d, want %h at cycle %0d", readdata, cyc, e.d, e.c);
        end
      end
    end
  end

  task automatic xfer(input logic we, input logic re, input logic [31:0] a, input logic [31:0] dat, output int stalls);
    exp_t e;
    stalls = 0;
    write = we; read = re; address = a; writedata = dat;
    @(negedge clk);
    while (waitrequest && stalls < 20) begin stalls++; @(negedge clk); end
    if (re && !we) begin
      e.d = a < 1024 ? model[a[9:2]] : ERR;
      e.c = cyc + RL;
      q.push_back(e);
    end
    if (we && a < 1024) model[a[9:2]] = dat;
    @(posedge clk); #1;
    write = 0; read = 0;
  endtask

  task automatic do_clear;
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    #1;
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL drain_timeout: %0d reads outstanding, want 0", q.size()); end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    total++;
    if ({waitrequest, readdatavalid, readdata, write_count, full, addr_error, proto_error} !== '0) begin
      bad++;
      $display("FAIL reset_state: wr=%b rdv=%b rd=%h cnt=%0d full=%b ae=%b pe=%b, want all 0",
        waitrequest, readdatavalid, readdata, write_count, full, addr_error, proto_error);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write;
    xfer(1, 0, 8, 32'h100, st);
    total++;
    if (st !== WC) begin bad++; $display("FAIL single_stalls: got %0d want %0d", st, WC); end
    total++;
    if (write_count !== 9'd1) begin bad++; $display("FAIL single_count: got %0d want 1", write_count); end
    xfer(0, 1, 8, 0, st);
    drain();
  endtask

  task automatic test_burst;
    do_clear();
    for (int i = 0; i < 256; i++) begin
      xfer(1, 0, i * 4, i, st);
      total++;
      if (write_count !== 9'(i + 1) || full !== (i == 255)) begin
        bad++;
        $display("FAIL burst_count[%0d]: cnt=%0d full=%b want cnt=%0d full=%b", i, write_count, full, i + 1, i == 255);
      end
    end
    xfer(1, 0, 0, 32'hAAAA, st);
    total++;
    if (write_count !== 9'd256 || full !== 1'b1) begin
      bad++;
      $display("FAIL burst_saturate: cnt=%0d full=%b want 256 1", write_count, full);
    end
  endtask

  task automatic test_readback;
    xfer(0, 1, 12, 0, st);
    total++;
    if (st !== WC) begin bad++; $display("FAIL read_stalls: got %0d want %0d", st, WC); end
    drain();
    xfer(0, 1, 0, 0, st);
    xfer(0, 1, 13, 0, st);
    xfer(0, 1, 1020, 0, st);
    drain();
  endtask

  task automatic test_oob;
    xfer(1, 0, 1024, 32'h1234, st);
    total++;
    if (addr_error !== 1'b1 || write_count !== 9'd256) begin
      bad++;
      $display("FAIL oob_write: ae=%b cnt=%0d want 1 256", addr_error, write_count);
    end
    xfer(0, 1, 2048, 0, st);
    xfer(0, 1, 0, 0, st);
    drain();
    do_clear();
    total++;
    if (addr_error !== 1'b0 || write_count !== 9'd0 || full !== 1'b0) begin
      bad++;
      $display("FAIL clear: ae=%b cnt=%0d full=%b want 0 0 0", addr_error, write_count, full);
    end
  endtask

  task automatic test_proto;
    xfer(1, 1, 0, 32'h55, st);
    total++;
    if (proto_error !== 1'b1 || write_count !== 9'd1) begin
      bad++;
      $display("FAIL proto: pe=%b cnt=%0d want 1 1", proto_error, write_count);
    end
    repeat (4) @(posedge clk);
    xfer(0, 1, 0, 0, st);
    drain();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1, 32'(i * 8), 0, st);
      total++;
      if (st !== WC) begin bad++; $display("FAIL b2b_stalls[%0d]: got %0d want %0d", i, st, WC); end
    end
    drain();
  endtask

  task automatic test_reset_mid;
    xfer(1, 0, 1024, 0, st);
    xfer(0, 1, 16, 0, st);
    write = 1; address = 20; writedata = 32'hBAD; rst = 1;
    @(negedge clk);
    total++;
    if (waitrequest !== 1'b1) begin bad++; $display("FAIL mid_stall: waitrequest=%b want 1", waitrequest); end
    q.delete();
    @(posedge clk); #1;
    rst = 0; write = 0;
    repeat (3) @(negedge clk);
    total++;
    if (write_count !== 9'd0 || addr_error !== 1'b0 || proto_error !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: cnt=%0d ae=%b pe=%b want 0 0 0", write_count, addr_error, proto_error);
    end
    @(posedge clk); #1;
    xfer(0, 1, 16, 0, st);
    xfer(0, 1, 20, 0, st);
    drain();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_readback();
    test_oob();
    test_proto();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
